// File: rtl/lcd_nibble_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_nibble_writer: HD44780 4-bit writer with autonomous power-on init.     |
// | Optional macro LCD_LINE_WRAP_EN inserts 0xC0/0x80 after 16/32 data bytes.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_nibble_writer #(
  parameter int T_POWERON = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_EN      = 12,
  parameter int T_NIB_GAP = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int CNT_W     = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iCommand,
  input  logic       iData_Ready,
  output logic       oReadyForData,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl
);

  typedef enum logic [2:0] {
    POWERON = 3'd0,
    PWRWAIT = 3'd1,
    SETUP   = 3'd2,
    ENABLE  = 3'd3,
    GAP     = 3'd4,
    WAIT    = 3'd5,
    IDLE    = 3'd6
  } lcdState_t;

  // Counter loads are value-1 so that a phase lasts exactly T_* cycles.
  localparam logic [CNT_W-1:0] LD_POWERON = CNT_W'(T_POWERON - 1);
  localparam logic [CNT_W-1:0] LD_INIT1   = CNT_W'(T_INIT1 - 1);
  localparam logic [CNT_W-1:0] LD_INIT2   = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] LD_EN      = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_GAP     = CNT_W'(T_NIB_GAP - 1);
  localparam logic [CNT_W-1:0] LD_CMD     = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(T_CLEAR - 1);

  lcdState_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [3:0]       step, stepNext;
  logic             lowNib, lowNibNext;
  logic [7:0]       curByte, curByteNext;
  logic             curRs, curRsNext;
  logic [3:0]       dataOut, dataOutNext;
  logic             rsOut, rsOutNext;
  logic             isClear;
`ifdef LCD_LINE_WRAP_EN
  logic [4:0]       col, colNext;
`endif

  // Steps 0-3 are single init nibbles (high half only), 4-7 the config bytes.
  function automatic logic [7:0] stepByte(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2: stepByte = 8'h30;
      4'd3:             stepByte = 8'h20;
      4'd4:             stepByte = 8'h28;
      4'd5:             stepByte = 8'h06;
      4'd6:             stepByte = 8'h0C;
      4'd7:             stepByte = 8'h01;
      default:          stepByte = 8'h00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] initWait(input logic [3:0] s);
    case (s)
      4'd0:    initWait = LD_INIT1;
      4'd1:    initWait = LD_INIT2;
      default: initWait = LD_CMD;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= POWERON;
      cnt     <= '0;
      step    <= 4'd0;
      lowNib  <= 1'b0;
      curByte <= 8'h00;
      curRs   <= 1'b0;
      dataOut <= 4'h0;
      rsOut   <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
      col     <= 5'd0;
`endif
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      step    <= stepNext;
      lowNib  <= lowNibNext;
      curByte <= curByteNext;
      curRs   <= curRsNext;
      dataOut <= dataOutNext;
      rsOut   <= rsOutNext;
`ifdef LCD_LINE_WRAP_EN
      col     <= colNext;
`endif
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = (cnt != '0) ? cnt - 1'b1 : cnt;
    stepNext    = step;
    lowNibNext  = lowNib;
    curByteNext = curByte;
    curRsNext   = curRs;
    dataOutNext = dataOut;
    rsOutNext   = rsOut;
`ifdef LCD_LINE_WRAP_EN
    colNext     = col;
`endif
    isClear = !curRs && (curByte == 8'h01 || curByte == 8'h02);

    case (state)
      POWERON: begin
        stateNext = PWRWAIT;
        cntNext   = LD_POWERON;
      end
      PWRWAIT: if (cnt == '0) begin
        stepNext    = 4'd0;
        curByteNext = stepByte(4'd0);
        curRsNext   = 1'b0;
        lowNibNext  = 1'b0;
        stateNext   = SETUP;
      end
      SETUP: begin
        stateNext = ENABLE;
        cntNext   = LD_EN;
      end
      ENABLE: if (cnt == '0) begin
        if (step < 4'd4) begin
          stateNext = WAIT;
          cntNext   = initWait(step);
        end else if (!lowNib) begin
          stateNext = GAP;
          cntNext   = LD_GAP;
        end else begin
          stateNext = WAIT;
          cntNext   = isClear ? LD_CLEAR : LD_CMD;
        end
      end
      GAP: if (cnt == '0) begin
        lowNibNext = 1'b1;
        stateNext  = SETUP;
      end
      WAIT: if (cnt == '0) begin
        if (step < 4'd7) begin
          stepNext    = step + 4'd1;
          curByteNext = stepByte(step + 4'd1);
          curRsNext   = 1'b0;
          lowNibNext  = 1'b0;
          stateNext   = SETUP;
        end else if (step == 4'd7) begin
          stepNext  = 4'd8;
          stateNext = IDLE;
        end else begin
          stateNext = IDLE;
`ifdef LCD_LINE_WRAP_EN
          // Column 16 means the first line is full; 0 after a data byte means wrap.
          if (curRs && (col == 5'd16 || col == 5'd0)) begin
            curByteNext = (col == 5'd16) ? 8'hC0 : 8'h80;
            curRsNext   = 1'b0;
            lowNibNext  = 1'b0;
            stateNext   = SETUP;
          end
`endif
        end
      end
      IDLE: if (iData_Ready) begin
        curByteNext = iData;
        curRsNext   = !iCommand;
        lowNibNext  = 1'b0;
        stateNext   = SETUP;
`ifdef LCD_LINE_WRAP_EN
        colNext     = iCommand ? 5'd0 : col + 5'd1;
`endif
      end
      default: stateNext = POWERON;
    endcase

    // Bus values change only when a setup cycle begins, then hold until the next one.
    if (stateNext == SETUP) begin
      dataOutNext = lowNibNext ? curByteNext[3:0] : curByteNext[7:4];
      rsOutNext   = curRsNext;
    end
  end

  assign oReadyForData           = (state == IDLE);
  assign oLCD_Enabled            = (state == ENABLE);
  assign oLCD_Data               = dataOut;
  assign oLCD_RegisterSelect     = rsOut;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule
`default_nettype wire
